// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the byte-serial adder family.
//   SLICE_W         : width of one adder slice (bits processed per beat)
//   seq_state_t     : sequencer state encoding (IDLE, RUN, DONE)
//   width_is_legal  : true when a word width is a whole number of slices
// ---------------------------------------------------------------------------
package adder_pkg;

   localparam int SLICE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_t;

   // A word can only be streamed through the slice if it splits into
   // complete bytes, and there must be at least one of them.
   function automatic bit width_is_legal(input int width);
      return (width >= SLICE_W) && ((width % SLICE_W) == 0);
   endfunction

endpackage

// File: rtl/kogge_stone_adder8bit.sv
// ---------------------------------------------------------------------------
// kogge_stone_adder8bit
// Purely combinational 8-bit parallel-prefix (Kogge-Stone) adder.
//   a, b  in  8  addends
//   cin   in  1  carry in
//   s     out 8  sum bits
//   cout  out 1  carry out of bit 7
// ---------------------------------------------------------------------------
module kogge_stone_adder8bit (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] s,
   output logic       cout
);

   logic [7:0] p0;
   logic [7:0] g0;
   logic [7:0] g1;
   logic [7:2] p1;
   logic [7:0] g2;
   logic [7:4] p2;
   logic [7:0] g3;
   logic [8:0] carry;

   // Bit-level generate/propagate. The carry in is folded into bit 0's
   // generate so that the prefix tree's group generates are the carries
   // into the next bit position directly.
   always_comb begin
      p0 = a ^ b;
      g0 = a & b;
      g0[0] = (a[0] & b[0]) | (p0[0] & cin);
   end

   // Prefix level 1 (span 1). Only the propagate bits that a later level
   // reads are kept.
   always_comb begin
      g1 = g0;
      p1 = '0;
      for (int i = 1; i < 8; i++) begin
         g1[i] = g0[i] | (p0[i] & g0[i-1]);
      end
      for (int i = 2; i < 8; i++) begin
         p1[i] = p0[i] & p0[i-1];
      end
   end

   // Prefix level 2 (span 2).
   always_comb begin
      g2 = g1;
      p2 = '0;
      for (int i = 2; i < 8; i++) begin
         g2[i] = g1[i] | (p1[i] & g1[i-2]);
      end
      for (int i = 4; i < 8; i++) begin
         p2[i] = p1[i] & p1[i-2];
      end
   end

   // Prefix level 3 (span 4). After this level g3[i] is the carry out of
   // bit i, including the external carry in.
   always_comb begin
      g3 = g2;
      for (int i = 4; i < 8; i++) begin
         g3[i] = g2[i] | (p2[i] & g2[i-4]);
      end
   end

   always_comb begin
      carry = {g3, cin};
      s     = p0 ^ carry[7:0];
      cout  = carry[8];
   end

endmodule

// File: rtl/word_adder_seq.sv
// ---------------------------------------------------------------------------
// word_adder_seq
// Multi-cycle WIDTH-bit add/subtract unit. One operand pair is accepted over
// a valid/ready handshake, streamed byte by byte (LSB first) through a single
// 8-bit Kogge-Stone slice with a registered carry between beats, and the
// registered result is offered downstream over a valid/ready handshake.
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      operand pair valid
//   in_ready   out  1      unit can accept an operand pair (IDLE)
//   a, b       in   WIDTH  operands
//   sub        in   1      0: a+b, 1: a-b (a + ~b + 1)
//   out_valid  out  1      result valid (DONE)
//   out_ready  in   1      downstream accepts the result
//   sum        out  WIDTH  result modulo 2^WIDTH
//   cout       out  1      carry out of MSB (for sub: 1 = no borrow)
//   overflow   out  1      signed two's-complement overflow
// ---------------------------------------------------------------------------
module word_adder_seq
   import adder_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int BEATS  = WIDTH / SLICE_W;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_RUN  = RUN;
   localparam logic [1:0] ST_DONE = DONE;

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   if (!width_is_legal(WIDTH)) begin : g_bad_width
      $error("word_adder_seq: WIDTH must be a multiple of 8 and at least 8");
   end

   logic [1:0]         state;
   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;
   logic               carry;
   logic [BEAT_W-1:0]  beat;

   int                 byte_lo;
   logic [SLICE_W-1:0] slice_a;
   logic [SLICE_W-1:0] slice_b;
   logic [SLICE_W-1:0] slice_s;
   logic               slice_cout;

   // Select the byte of the latched operands that the current beat works on.
   // b_reg already holds the inverted operand for subtraction, so the slice
   // only ever adds.
   always_comb begin
      byte_lo = SLICE_W * int'(beat);
      slice_a = a_reg[byte_lo +: SLICE_W];
      slice_b = b_reg[byte_lo +: SLICE_W];
   end

   kogge_stone_adder8bit u_slice (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (carry),
      .s    (slice_s),
      .cout (slice_cout)
   );

   // Handshake flags are pure decodes of the state register, so neither
   // depends combinationally on the other side's valid/ready.
   always_comb begin
      in_ready  = (state == ST_IDLE);
      out_valid = (state == ST_DONE);
   end

   // Sequencer. The accept edge captures the operands (with B pre-inverted
   // and the carry seeded by sub), each RUN edge retires one byte, and the
   // final byte also produces the word-level carry and signed overflow.
   // Overflow compares sign bits of the operands actually added (A and B'),
   // so the same rule covers both add and subtract.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         a_reg    <= '0;
         b_reg    <= '0;
         carry    <= 1'b0;
         beat     <= '0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  a_reg <= a;
                  b_reg <= b ^ {WIDTH{sub}};
                  carry <= sub;
                  beat  <= '0;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               sum[byte_lo +: SLICE_W] <= slice_s;
               carry <= slice_cout;
               beat  <= beat + BEAT_W'(1);
               if (beat == LAST_BEAT) begin
                  state    <= ST_DONE;
                  cout     <= slice_cout;
                  overflow <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                              (slice_s[SLICE_W-1] != a_reg[WIDTH-1]);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
